// File: rtl/coef_seq_pkg.sv
// Shared types and constants for the coefficient table sequencer.
// Contents: table geometry, coefficient/table types, FSM state enum and
// the reset image of the table.
package coef_seq_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned RC_W   = 2;

    typedef logic [DATA_W-1:0] coef_t;
    typedef coef_t [ROWS-1:0][COLS-1:0] coef_table_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        ZTERM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reset contents: entry [r][c] holds 4*r+c.
    function automatic coef_table_t default_table();
        coef_table_t t;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                t[r][c] = DATA_W'(COLS * unsigned'(r) + unsigned'(c));
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/coef_seq_ctrl_table.sv
// 4x4 coefficient register file.
// Ports:
//   clk, rst            clock, async active-high reset (restores default_table)
//   we, wrow, wcol      synchronous write enable and address
//   wdata               write data
//   ridx                row-major read index (row = ridx[3:2], col = ridx[1:0])
//   rdata_c             combinational read data
module coef_table
    import coef_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] wrow,
    input  logic [1:0] wcol,
    input  logic [7:0] wdata,
    input  logic [3:0] ridx,
    output logic [7:0] rdata_c
);

    coef_table_t tbl;

    // Storage with single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl <= default_table();
        end else if (we) begin
            tbl[wrow][wcol] <= wdata;
        end
    end

    assign rdata_c = tbl[ridx[3:2]][ridx[1:0]];

endmodule

// File: rtl/coef_seq_ctrl.sv
// Sequencer/arbiter for the 4x4 coefficient table feeding XOUT.
// Computes xout = a - 3*b - TEMP*sum(table) (8-bit wrap), walking one entry
// per cycle in row-major order. Config writes are accepted only while idle.
// Optional macro COEF_SEQ_ZTERM_EN adds one ZTERM cycle (acc += 11*ZCOEF).
// Ports:
//   clk, rst                          clock, async active-high reset
//   cfg_valid/cfg_ready               table write handshake
//   cfg_row, cfg_col, cfg_data        write address and data
//   start, a, b                       compute request and operands
//   busy                              high during WALK/ZTERM
//   xout, xout_valid                  result and one-cycle valid pulse
module coef_seq_ctrl
    import coef_seq_pkg::*;
#(
    parameter logic [7:0] TEMP  = 8'd21
`ifdef COEF_SEQ_ZTERM_EN
    ,
    parameter logic [7:0] ZCOEF = 8'd1
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_row,
    input  logic [1:0] cfg_col,
    input  logic [7:0] cfg_data,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic [7:0] xout,
    output logic       xout_valid
);

`ifdef COEF_SEQ_ZTERM_EN
    localparam logic [7:0] ZADD = 8'(8'd11 * ZCOEF);
`endif

    state_t     state, state_next;
    logic [7:0] acc, acc_next;
    logic [3:0] idx, idx_next;
    logic [7:0] xout_next;
    logic       xout_load;
    logic       we_c;
    logic [7:0] rd_c;

    coef_table u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (we_c),
        .wrow    (cfg_row),
        .wcol    (cfg_col),
        .wdata   (cfg_data),
        .ridx    (idx),
        .rdata_c (rd_c)
    );

    // Writes land only in IDLE, including the cycle a START is accepted.
    assign we_c = cfg_valid && (state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        idx_next   = idx;
        xout_load  = 1'b0;
        xout_next  = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = a - 8'(b * 8'd3);
                    idx_next   = 4'd0;
                    state_next = WALK;
                end
            end
            WALK: begin
                acc_next = acc - 8'(TEMP * rd_c);
                idx_next = idx + 4'd1;
                if (idx == 4'd15) begin
`ifdef COEF_SEQ_ZTERM_EN
                    state_next = ZTERM;
`else
                    state_next = DONE;
                    xout_load  = 1'b1;
                    xout_next  = acc_next;
`endif
                end
            end
            ZTERM: begin
`ifdef COEF_SEQ_ZTERM_EN
                acc_next   = acc + ZADD;
                state_next = DONE;
                xout_load  = 1'b1;
                xout_next  = acc_next;
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs; xout loads on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= 8'd0;
            idx        <= 4'd0;
            xout       <= 8'd0;
            xout_valid <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            acc        <= acc_next;
            idx        <= idx_next;
            xout_valid <= xout_load;
            if (xout_load) begin
                xout <= xout_next;
            end
            busy      <= (state_next == WALK) || (state_next == ZTERM);
            cfg_ready <= (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_coef_seq_ctrl.sv
// Directed self-checking bench for coef_seq_ctrl.
module tb_coef_seq_ctrl;

`ifdef COEF_SEQ_ZTERM_EN
    localparam int LAT  = 18;
    localparam int ZADD = 11;
`else
    localparam int LAT  = 17;
    localparam int ZADD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_row;
    logic [1:0] cfg_col;
    logic [7:0] cfg_data;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic [7:0] xout;
    logic       xout_valid;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    coef_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_data   (cfg_data),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .xout       (xout),
        .xout_valid (xout_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Accept a START; returns in cycle 1 (first WALK cycle).
    task automatic start_run(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) for xout_valid from cycle cyc0, then check latency, value, hold.
    task automatic wait_result(input string tag, input int cyc0, input logic [7:0] expv);
        int cyc;
        cyc = cyc0;
        while (xout_valid !== 1'b1 && cyc < 40) begin
            check({tag, "_busy_walk"}, 32'(busy), 32'd1);
            step();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check({tag, "_xout"}, 32'(xout), 32'(expv));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_rdy_done"}, 32'(cfg_ready), 32'd0);
        step();
        check({tag, "_valid_pulse"}, 32'(xout_valid), 32'd0);
        check({tag, "_xout_hold"}, 32'(xout), 32'(expv));
        check({tag, "_rdy_idle"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_row   = 2'd0;
        cfg_col   = 2'd0;
        cfg_data  = 8'd0;
        start     = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_xout", 32'(xout), 32'd0);
        check("rst_valid", 32'(xout_valid), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        step();

        // 1: default table
        start_run(8'd100, 8'd10);
        wait_result("t1", 1, 8'(110 + ZADD));

        // 2: write [1][2]=0
        cfg_valid = 1'b1; cfg_row = 2'd1; cfg_col = 2'd2; cfg_data = 8'd0;
        check("t2_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        start_run(8'd100, 8'd10);
        wait_result("t2", 1, 8'(236 + ZADD));

        // 3: write [0][0]=10 in the same cycle as START, from reset table
        do_reset();
        cfg_valid = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_data = 8'd10;
        start_run(8'd100, 8'd10);
        cfg_valid = 1'b0;
        wait_result("t3", 1, 8'(156 + ZADD));

        // 4: write held while busy stalls; mid-walk START ignored
        do_reset();
        start_run(8'd100, 8'd10);
        cfg_valid = 1'b1; cfg_row = 2'd1; cfg_col = 2'd2; cfg_data = 8'd0;
        step();
        step();
        step();
        check("t4_ready_busy", 32'(cfg_ready), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_result("t4", 5, 8'(110 + ZADD));
        step();
        cfg_valid = 1'b0;
        check("t4_no_restart", 32'(busy), 32'd0);
        start_run(8'd100, 8'd10);
        wait_result("t4b", 1, 8'(236 + ZADD));

        // 5: async reset at cycle 5 of a walk restores everything
        start_run(8'd100, 8'd10);
        step();
        step();
        step();
        step();
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_xout_rst", 32'(xout), 32'd0);
        check("t5_valid_rst", 32'(xout_valid), 32'd0);
        check("t5_ready_rst", 32'(cfg_ready), 32'd1);
        #1 rst = 1'b0;
        step();
        start_run(8'd100, 8'd10);
        wait_result("t5", 1, 8'(110 + ZADD));

        // 6: zero table, zero operands
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cfg_valid = 1'b1;
                cfg_row   = 2'(r);
                cfg_col   = 2'(c);
                cfg_data  = 8'd0;
                check("t6_ready", 32'(cfg_ready), 32'd1);
                step();
            end
        end
        cfg_valid = 1'b0;
        start_run(8'd0, 8'd0);
        wait_result("t6", 1, 8'(ZADD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
